ks_pluck_sched: RTL

//   Shares one Karplus-Strong pluck-burst generator among N_STR strings.

---
 rtl/ks_pluck_sched_if.sv | 29 ++
 rtl/ks_pluck_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ks_pluck_sched_if.sv
// Pluck requests from the string front end and burst control back to the shared
// Karplus-Strong burst generator and delay-line router.
interface ks_pluck_sched_if #(
  parameter int unsigned N_STR = 6,
  parameter int unsigned SW    = 3,
  parameter int unsigned LW    = 10
);
  logic [N_STR-1:0]    pluck_in;
  logic [N_STR*LW-1:0] lengths;
  logic                burst_pluck;
  logic [LW-1:0]       burst_length;
  logic [SW-1:0]       burst_sel;
  logic                burst_active;
  logic [N_STR-1:0]    burst_onehot;
  logic [N_STR-1:0]    pending;
  logic                dropped;

  modport master (
    output pluck_in, lengths,
    input  burst_pluck, burst_length, burst_sel, burst_active,
    input  burst_onehot, pending, dropped
  );

  modport slave (
    input  pluck_in, lengths,
    output burst_pluck, burst_length, burst_sel, burst_active,
    output burst_onehot, pending, dropped
  );
endinterface

// File: rtl/ks_pluck_sched.sv
// Round-robin scheduler sharing one pluck-burst generator among N_STR strings:
// edge-detects plucks, queues them, and issues one registered burst at a time.
module ks_pluck_sched #(
  parameter int unsigned N_STR     = 6,
  parameter int unsigned SW        = 3,
  parameter int unsigned LW        = 10,
  parameter int unsigned GAP       = 2,
  parameter int unsigned INIT_WAIT = 1023
) (
  input logic             lrck,
  input logic             rst_n,
  ks_pluck_sched_if.slave bus
);

  localparam int unsigned IW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int unsigned GW = 4;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FIRE, S_RUN, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [N_STR-1:0] prev_q, prev_d;
  logic [N_STR-1:0] pend_q, pend_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    init_q, init_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pluck_q, pluck_d;
  logic [LW-1:0]    len_q, len_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             active_q, active_d;
  logic [N_STR-1:0] onehot_q, onehot_d;
  logic             drop_q, drop_d;

  logic [N_STR-1:0] rise, gnt_mask;
  logic [LW-1:0]    len_arr [N_STR];
  logic             gnt_vld;
  logic [SW-1:0]    gnt_idx, idx;

  assign rise = bus.pluck_in & ~prev_q;

  always_comb begin
    for (int i = 0; i < int'(N_STR); i++) len_arr[i] = bus.lengths[i*LW +: LW];
  end

  // Round-robin search starting just after the last granted string
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= int'(N_STR); k++) begin
      idx = SW'((32'(rr_q) + 32'(k)) % N_STR);
      if (!gnt_vld && pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = bus.pluck_in;
    pend_d   = pend_q;
    rr_d     = rr_q;
    init_d   = init_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    len_d    = len_q;
    sel_d    = sel_q;
    drop_d   = 1'b0;
    gnt_mask = '0;

    unique case (state_q)
      S_INIT: begin
        if (INIT_WAIT <= 1 || init_q == IW'(INIT_WAIT - 1)) state_d = S_IDLE;
        else init_d = init_q + IW'(1);
      end
      S_IDLE: begin
        if (gnt_vld) begin
          gnt_mask = N_STR'(1) << gnt_idx;
          rr_d     = gnt_idx;
          sel_d    = gnt_idx;
          len_d    = len_arr[gnt_idx];
          state_d  = S_FIRE;
        end
      end
      S_FIRE: begin
        cnt_d = len_q;
        gap_d = '0;
        if (len_q != '0) state_d = S_RUN;
        else state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_RUN: begin
        cnt_d = cnt_q - LW'(1);
        gap_d = '0;
        if (cnt_q == LW'(1)) state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = S_INIT;
    endcase

    // Plucks during start-up settle are ignored; a grant and a new rise on the same string keep it queued
    if (state_q != S_INIT) begin
      drop_d = |(rise & pend_q & ~gnt_mask);
      pend_d = (pend_q & ~gnt_mask) | rise;
    end

    pluck_d  = (state_d == S_FIRE);
    active_d = (state_d == S_FIRE) || (state_d == S_RUN);
    onehot_d = active_d ? (N_STR'(1) << sel_d) : '0;
  end

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      prev_q   <= '0;
      pend_q   <= '0;
      rr_q     <= SW'(N_STR - 1);
      init_q   <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      pluck_q  <= 1'b0;
      len_q    <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
      onehot_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      init_q   <= init_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      pluck_q  <= pluck_d;
      len_q    <= len_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      onehot_q <= onehot_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.burst_pluck  = pluck_q;
  assign bus.burst_length = len_q;
  assign bus.burst_sel    = sel_q;
  assign bus.burst_active = active_q;
  assign bus.burst_onehot = onehot_q;
  assign bus.pending      = pend_q;
  assign bus.dropped      = drop_q;

endmodule
